// File: rtl/modexp_controller.sv
// modexp_controller: request/response front end that drives a modular-exponentiation engine over a set/finished handshake.
// Define MODEXP_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES cycles with an error response.
module modexp_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_base,
    input  logic [DATA_WIDTH-1:0] req_exp,
    input  logic [DATA_WIDTH-1:0] req_modulant,
    input  logic [DATA_WIDTH-1:0] req_r_div_two,
    input  logic [DATA_WIDTH-1:0] req_r_squared,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic [DATA_WIDTH-1:0] exp_a,
    output logic [DATA_WIDTH-1:0] exp_b,
    output logic [DATA_WIDTH-1:0] exp_modulant,
    output logic [DATA_WIDTH-1:0] exp_r_div_two,
    output logic [DATA_WIDTH-1:0] exp_r_squared,
    output logic                  exp_set,
    input  logic [DATA_WIDTH-1:0] exp_out,
    input  logic                  exp_finished
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state;
`ifdef MODEXP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign rsp_error = 1'b0;
`endif
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            exp_set       <= 1'b0;
            exp_a         <= '0;
            exp_b         <= '0;
            exp_modulant  <= '0;
            exp_r_div_two <= '0;
            exp_r_squared <= '0;
`ifdef MODEXP_TIMEOUT_EN
            rsp_error     <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    exp_a         <= req_base;
                    exp_b         <= req_exp;
                    exp_modulant  <= req_modulant;
                    exp_r_div_two <= req_r_div_two;
                    exp_r_squared <= req_r_squared;
                    exp_set       <= 1'b1;
                    req_ready     <= 1'b0;
                    state         <= ISSUE;
                end
                // exp_finished may still be high from the previous operation here, so it is not looked at
                ISSUE: begin
                    exp_set <= 1'b0;
                    state   <= WAIT;
`ifdef MODEXP_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: if (exp_finished) begin
                    rsp_data  <= exp_out;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
`ifdef MODEXP_TIMEOUT_EN
                    rsp_error <= 1'b0;
                end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data  <= '0;
                    rsp_error <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
`endif
                end
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/modexp_controller.md
MODEXP_CONTROLLER -- requirements
Module: modexp_controller

Interface
REQ-001 Parameter DATA_WIDTH, 8, operand/result width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort (used only with MODEXP_TIMEOUT_EN).
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_base, req_exp, req_modulant, req_r_div_two, req_r_squared  in  DATA_WIDTH each  operands and Montgomery constants.
REQ-008 rsp_valid  out  1  result present.
REQ-009 rsp_ready  in  1  consumer takes result.
REQ-010 rsp_data  out  DATA_WIDTH  result.
REQ-011 rsp_error  out  1  result aborted by timeout.
REQ-012 exp_a, exp_b, exp_modulant, exp_r_div_two, exp_r_squared  out  DATA_WIDTH each  engine operands.
REQ-013 exp_set  out  1  engine start strobe.
REQ-014 exp_out  in  DATA_WIDTH  engine result.
REQ-015 exp_finished  in  1  engine done level.

Function
REQ-016 The controller SHALL be the initiator of the engine set/finished protocol, with states IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: req_ready=1; on req_valid&&req_ready all five request fields SHALL be registered into exp_* outputs and state SHALL go to ISSUE.
REQ-018 ISSUE: exp_set=1 for exactly one cycle; exp_finished SHALL be ignored; next state WAIT.
REQ-019 exp_* operand outputs SHALL remain stable from ISSUE until the next accepted request.
REQ-020 WAIT: when exp_finished=1, exp_out SHALL be registered into rsp_data, rsp_error=0, next state DONE.
REQ-021 DONE: rsp_valid=1 with rsp_data/rsp_error held stable until rsp_valid&&rsp_ready, then next state IDLE.
REQ-022 req_ready SHALL be 0 in ISSUE, WAIT, DONE; no same-cycle request acceptance on the response handshake cycle.
REQ-023 Latency: request accepted at edge N, exp_set high during cycle N+1, finished first seen at cycle M>=N+2, rsp_valid high from cycle M+1.
REQ-024 exp_set SHALL never be asserted outside ISSUE.
REQ-025 req_* changes while req_ready=0 SHALL have no effect.

Reset
REQ-026 reset_n=0 SHALL immediately force state IDLE, req_ready=1 after release, rsp_valid=0, rsp_error=0, rsp_data=0, exp_set=0, all exp_* operands 0, timeout counter 0.
REQ-027 Reset asserted in any state (including mid-WAIT) SHALL discard the operation; a later stale exp_finished SHALL not produce a response.

Configuration
REQ-028 Macro MODEXP_TIMEOUT_EN defined: a counter SHALL count WAIT cycles; if it reaches TIMEOUT_CYCLES with exp_finished=0, state SHALL go DONE with rsp_data=0, rsp_error=1; counter SHALL clear on entering WAIT.
REQ-029 With MODEXP_TIMEOUT_EN, exp_finished=1 in the same cycle the limit is reached SHALL take priority (normal result, rsp_error=0).
REQ-030 MODEXP_TIMEOUT_EN undefined: no counter; WAIT SHALL persist until exp_finished; rsp_error SHALL be constant 0.

Verification
REQ-031 Single op: base=0x05, exp=0x03, engine model returns 0x7D with finished 4 cycles after set -> exp_set one cycle, rsp_valid with rsp_data=0x7D, rsp_error=0, latency per REQ-023.
REQ-032 Back-pressure: rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_data stays 0x7D, req_ready stays 0; rsp_ready=1 -> IDLE next cycle, req_ready=1.
REQ-033 Stale finished: engine holds exp_finished=1 from prior op during ISSUE, then drops -> controller does not complete in ISSUE; completes on next real finished.
REQ-034 Reset mid-WAIT: reset_n=0 two cycles after exp_set, engine later raises finished -> no rsp_valid, exp_set=0, req_ready=1 after release.
REQ-035 Timeout (MODEXP_TIMEOUT_EN, TIMEOUT_CYCLES=8): engine never finishes -> rsp_valid with rsp_data=0x00, rsp_error=1 after 8 WAIT cycles; finished on cycle 8 -> rsp_error=0.
REQ-036 Back-to-back: two requests (0x02^0x05, 0x03^0x02) with rsp_ready=1 -> two responses in order, exactly two exp_set pulses, operands stable per REQ-019.
